vga_ctrl: RTL and testbench

VGA_CTRL -- requirements
Module: vga_ctrl

---
 rtl/vga_ctrl_pkg.sv | 24 ++
 rtl/vga_axis_counter.sv | 43 ++++
 rtl/vga_ctrl.sv | 124 ++++++++++++
 tb/tb_vga_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vga_ctrl_pkg.sv
// Shared types for the VGA timing controller: pixel colour, per-stage timing flags
// and a counter-width helper.
package vga_ctrl_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } color_t;

   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
   } vga_timing_t;

   localparam vga_timing_t TIMING_IDLE = '{active: 1'b0, hsync: 1'b0, vsync: 1'b0};

   // Keeps single-value ranges at one bit instead of collapsing to zero width.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with active and sync region decode.
// Region flags are combinational from the count; the count advances only when inc=1.
module vga_axis_counter
   import vga_ctrl_pkg::*;
#(
   parameter int unsigned ACTIVE = 800,
   parameter int unsigned FPORCH = 56,
   parameter int unsigned SYNC   = 120,
   parameter int unsigned BPORCH = 64,
   localparam int unsigned FULL  = ACTIVE + FPORCH + SYNC + BPORCH,
   localparam int unsigned CW    = cnt_width(FULL)
) (
   input  logic          pixelclk,
   input  logic          rst,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          active,
   output logic          sync
);

   if (ACTIVE == 0 || FPORCH == 0 || SYNC == 0 || BPORCH == 0) begin : g_bad_region
      $error("vga_axis_counter: every region length must be non-zero");
   end

   localparam logic [CW-1:0] LAST     = CW'(FULL - 1);
   localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FPORCH);
   localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FPORCH + SYNC - 1);

   always_ff @(posedge pixelclk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= wrap ? '0 : count + CW'(1);
      end
   end

   assign wrap   = (count == LAST);
   assign active = (count < ACT_END);
   assign sync   = (count >= SYNC_BEG) && (count <= SYNC_END);

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: combinational pixel request from h/v counters, with de, syncs
// and colour delayed LATENCY+1 cycles to line up with the pixel source; en stalls timing.
module vga_ctrl
   import vga_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = 800,
   parameter int unsigned HEIGHT      = 600,
   parameter int unsigned HORI_FPORCH = 56,
   parameter int unsigned HORI_SYNC   = 120,
   parameter int unsigned HORI_BPORCH = 64,
   parameter int unsigned VERT_FPORCH = 37,
   parameter int unsigned VERT_SYNC   = 6,
   parameter int unsigned VERT_BPORCH = 23,
   parameter bit          HSYNC_POL   = 1'b1,
   parameter bit          VSYNC_POL   = 1'b1,
   parameter int          LATENCY     = 2,
   localparam int unsigned XW         = cnt_width(WIDTH),
   localparam int unsigned YW         = cnt_width(HEIGHT)
) (
   input  logic          pixelclk,
   input  logic          rst,
   input  logic          en,
   input  color_t        color_in,
   output logic          pix_req,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          frame_start,
   output logic          line_start,
   output color_t        color_out,
   output logic          de,
   output logic          vga_hsync,
   output logic          vga_vsync
);

   if (LATENCY < 0 || LATENCY > 8) begin : g_bad_latency
      $error("vga_ctrl: LATENCY must be within 0..8");
   end
   if (WIDTH == 0 || HEIGHT == 0) begin : g_bad_size
      $error("vga_ctrl: WIDTH and HEIGHT must be non-zero");
   end

   localparam int unsigned FULL_LINE  = WIDTH + HORI_FPORCH + HORI_SYNC + HORI_BPORCH;
   localparam int unsigned FULL_FRAME = HEIGHT + VERT_FPORCH + VERT_SYNC + VERT_BPORCH;
   localparam int unsigned HW         = cnt_width(FULL_LINE);
   localparam int unsigned VW         = cnt_width(FULL_FRAME);

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          h_wrap, h_active, h_sync;
   logic          v_wrap_unused, v_active, v_sync;
   logic          v_inc;

   vga_timing_t   req_timing;
   vga_timing_t   pipe [LATENCY+1];
   color_t        color_q;

   vga_axis_counter #(
      .ACTIVE (WIDTH),
      .FPORCH (HORI_FPORCH),
      .SYNC   (HORI_SYNC),
      .BPORCH (HORI_BPORCH)
   ) u_hcnt (
      .pixelclk (pixelclk),
      .rst      (rst),
      .inc      (en),
      .count    (h),
      .wrap     (h_wrap),
      .active   (h_active),
      .sync     (h_sync)
   );

   // Vertical steps only on the horizontal wrap, so both axes roll over together.
   assign v_inc = en & h_wrap;

   vga_axis_counter #(
      .ACTIVE (HEIGHT),
      .FPORCH (VERT_FPORCH),
      .SYNC   (VERT_SYNC),
      .BPORCH (VERT_BPORCH)
   ) u_vcnt (
      .pixelclk (pixelclk),
      .rst      (rst),
      .inc      (v_inc),
      .count    (v),
      .wrap     (v_wrap_unused),
      .active   (v_active),
      .sync     (v_sync)
   );

   assign pix_req     = en & h_active & v_active;
   assign pix_x       = pix_req ? h[XW-1:0] : '0;
   assign pix_y       = pix_req ? v[YW-1:0] : '0;
   assign line_start  = en & (h == '0);
   assign frame_start = line_start & (v == '0);

   // A stalled cycle injects idle flags, so the pipe drains to blanking while en=0.
   always_comb begin
      req_timing        = TIMING_IDLE;
      req_timing.active = pix_req;
      req_timing.hsync  = en & h_sync;
      req_timing.vsync  = en & v_sync;
   end

   always_ff @(posedge pixelclk) begin
      if (rst) begin
         for (int i = 0; i <= LATENCY; i++) begin
            pipe[i] <= TIMING_IDLE;
         end
         color_q <= '0;
      end else begin
         pipe[0] <= req_timing;
         for (int i = 1; i <= LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
         color_q <= color_in;
      end
   end

   assign de        = pipe[LATENCY].active;
   assign color_out = de ? color_q : '0;
   assign vga_hsync = pipe[LATENCY].hsync ? HSYNC_POL : ~HSYNC_POL;
   assign vga_vsync = pipe[LATENCY].vsync ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: tb/tb_vga_ctrl.sv
// Scoreboard bench for vga_ctrl on a tiny 4x3 raster with randomized en/rst traffic.
module tb_vga_ctrl;
   import vga_ctrl_pkg::*;

   localparam int W = 4, H = 3;
   localparam int HF = 1, HS = 2, HB = 1;
   localparam int VF = 1, VS = 1, VB = 1;
   localparam int LAT = 2;
   localparam int FL = W + HF + HS + HB;
   localparam int FF = H + VF + VS + VB;
   localparam bit HPOL = 1'b0, VPOL = 1'b1;

   logic       pixelclk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   color_t     color_in = '0;
   color_t     color_out;
   logic       pix_req, frame_start, line_start, de, vga_hsync, vga_vsync;
   logic [1:0] pix_x, pix_y;

   always #5 pixelclk = ~pixelclk;

   vga_ctrl #(
      .WIDTH(W), .HEIGHT(H),
      .HORI_FPORCH(HF), .HORI_SYNC(HS), .HORI_BPORCH(HB),
      .VERT_FPORCH(VF), .VERT_SYNC(VS), .VERT_BPORCH(VB),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .LATENCY(LAT)
   ) dut (
      .pixelclk(pixelclk), .rst(rst), .en(en), .color_in(color_in),
      .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .line_start(line_start),
      .color_out(color_out), .de(de), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
   );

   typedef struct { int due; bit req; int x; int y; bit ls; bit fs; } req_e;
   typedef struct { int due; bit de; bit hs; bit vs; int x; int y; } out_e;

   req_e        req_q[$];
   out_e        out_q[$];
   logic [19:0] rnd_hist [int];
   int          hist_x[$], hist_y[$];
   int          cyc = -1;
   int          hm = 0, vm = 0;
   int          n_chk = 0, n_fail = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d (h=%0d v=%0d model): got %0h, expected %0h",
                  name, cyc, hm, vm, act, exp);
      end
   endfunction

   // One raster cycle: drive inputs, record what the spec says must appear, advance the model.
   task automatic step(input bit r, input bit e);
      req_e        rq;
      out_e        oe;
      bit          vis;
      int          cx, cy;
      logic [19:0] rnd;
      @(posedge pixelclk);
      #1;
      cyc++;
      rst = r;
      en  = e;
      vis = e && hm < W && vm < H;
      cx  = hist_x.pop_front();
      cy  = hist_y.pop_front();
      hist_x.push_back(vis ? hm : 0);
      hist_y.push_back(vis ? vm : 0);
      rnd = 20'($urandom);
      rnd_hist[cyc] = rnd;
      color_in = {rnd, 2'(cy), 2'(cx)};

      rq = '{due: cyc, req: vis, x: vis ? hm : 0, y: vis ? vm : 0,
             ls: e && hm == 0, fs: e && hm == 0 && vm == 0};
      req_q.push_back(rq);
      oe = '{due: cyc + LAT + 1, de: vis,
             hs: e && hm >= W + HF && hm < W + HF + HS,
             vs: e && vm >= H + VF && vm < H + VF + VS,
             x: hm, y: vm};
      out_q.push_back(oe);

      if (r) begin
         foreach (out_q[i]) begin
            if (out_q[i].due > cyc) begin
               out_q[i].de = 1'b0;
               out_q[i].hs = 1'b0;
               out_q[i].vs = 1'b0;
            end
         end
         hm = 0;
         vm = 0;
      end else if (e) begin
         hm = hm + 1;
         if (hm == FL) begin
            hm = 0;
            vm = (vm == FF - 1) ? 0 : vm + 1;
         end
      end
   endtask

   initial begin : monitor
      req_e        rq;
      out_e        oe;
      logic [23:0] exp_col;
      forever begin
         @(negedge pixelclk);
         if (req_q.size() != 0 && req_q[0].due == cyc) begin
            rq = req_q.pop_front();
            chk("pix_req",     32'(pix_req),     32'(rq.req));
            chk("pix_x",       32'(pix_x),       32'(rq.x));
            chk("pix_y",       32'(pix_y),       32'(rq.y));
            chk("line_start",  32'(line_start),  32'(rq.ls));
            chk("frame_start", 32'(frame_start), 32'(rq.fs));
         end
         if (out_q.size() != 0 && out_q[0].due == cyc) begin
            oe = out_q.pop_front();
            exp_col = oe.de ? {rnd_hist[cyc-1], 2'(oe.y), 2'(oe.x)} : 24'd0;
            chk("de",        32'(de),        32'(oe.de));
            chk("vga_hsync", 32'(vga_hsync), 32'(oe.hs ? HPOL : !HPOL));
            chk("vga_vsync", 32'(vga_vsync), 32'(oe.vs ? VPOL : !VPOL));
            chk("color_out", 32'(color_out), 32'(exp_col));
         end
      end
   end

   initial begin : stimulus
      hist_x = '{0, 0};
      hist_y = '{0, 0};
      for (int i = 0; i <= LAT; i++) begin
         out_q.push_back('{due: i, de: 1'b0, hs: 1'b0, vs: 1'b0, x: 0, y: 0});
      end
      repeat (2) @(posedge pixelclk);

      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      repeat (2 * FL * FF + 4) step(1'b0, 1'b1);

      for (int i = 0; i < FL * FF && !(hm == 5 && vm == 2); i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (20) step(1'b0, 1'b1);

      for (int i = 0; i < FL * FF && !(hm == 2 && vm == 1); i++) step(1'b0, 1'b1);
      repeat (10) step(1'b0, 1'b0);
      repeat (60) step(1'b0, 1'b1);

      repeat (3000) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
      repeat (LAT + 2) step(1'b0, 1'b0);
      @(posedge pixelclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
